// File: rtl/wb_collector.sv
// wb_collector: per-channel writeback FIFOs drained round-robin onto one scoreboard port.
// Defining WB_COLLECTOR_BYPASS_EN lets an input to an empty FIFO reach wb_* combinationally.
module wb_collector #(
  parameter int unsigned NR_IN_PORTS   = 5,
  parameter int unsigned FIFO_DEPTH    = 2,
  parameter int unsigned TRANS_ID_BITS = 3,
  // Exception layout: {cause[63:0], tval[63:0], valid}
  parameter int unsigned EX_BITS       = 129
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic                                         flush_i,
  input  logic [NR_IN_PORTS-1:0]                       in_valid_i,
  input  logic [NR_IN_PORTS-1:0][TRANS_ID_BITS-1:0]    in_trans_id_i,
  input  logic [NR_IN_PORTS-1:0][63:0]                 in_result_i,
  input  logic [NR_IN_PORTS-1:0][EX_BITS-1:0]          in_ex_i,
  output logic [NR_IN_PORTS-1:0]                       in_full_o,
  output logic                                         wb_valid_o,
  output logic [TRANS_ID_BITS-1:0]                     wb_trans_id_o,
  output logic [63:0]                                  wb_result_o,
  output logic [EX_BITS-1:0]                           wb_ex_o,
  output logic                                         overflow_o
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned PORT_W = (NR_IN_PORTS > 1) ? $clog2(NR_IN_PORTS) : 1;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [63:0]              result;
    logic [EX_BITS-1:0]       ex;
  } entry_t;

  entry_t                            r_mem [NR_IN_PORTS][FIFO_DEPTH];
  logic [NR_IN_PORTS-1:0][PTR_W-1:0] r_rd_ptr;
  logic [NR_IN_PORTS-1:0][PTR_W-1:0] r_wr_ptr;
  logic [NR_IN_PORTS-1:0][CNT_W-1:0] r_cnt;
  logic [PORT_W-1:0]                 r_rr_ptr;
  logic                              r_overflow;
  entry_t                            r_wb;
`ifndef WB_COLLECTOR_BYPASS_EN
  logic                              r_wb_valid;
`endif

  entry_t [NR_IN_PORTS-1:0] w_in_entry;
  entry_t [NR_IN_PORTS-1:0] w_head;
  logic   [NR_IN_PORTS-1:0] w_nonempty;
  logic   [NR_IN_PORTS-1:0] w_fifo_full;
  logic   [NR_IN_PORTS-1:0] w_cand;
  logic   [NR_IN_PORTS-1:0] w_push;
  logic   [NR_IN_PORTS-1:0] w_pop;
  logic   [NR_IN_PORTS-1:0] w_drop;
  logic                     w_any;
  logic                     w_bypass;
  logic   [PORT_W-1:0]      w_win;
  logic   [PORT_W-1:0]      w_rr_next;
  entry_t                   w_win_entry;
  entry_t                   w_wb_out;

  // Per-channel FIFO status and almost-full credit flag.
  always_comb begin
    for (int unsigned k = 0; k < NR_IN_PORTS; k++) begin
      w_in_entry[k]  = {in_trans_id_i[k], in_result_i[k], in_ex_i[k]};
      w_head[k]      = r_mem[k][r_rd_ptr[k]];
      w_nonempty[k]  = (r_cnt[k] != '0);
      w_fifo_full[k] = (r_cnt[k] == CNT_W'(FIFO_DEPTH));
      in_full_o[k]   = (r_cnt[k] >= CNT_W'(FIFO_DEPTH - 1));
    end
  end

`ifdef WB_COLLECTOR_BYPASS_EN
  // Inputs to empty FIFOs compete too, except in a flush cycle.
  assign w_cand = w_nonempty | (in_valid_i & ~w_nonempty & {NR_IN_PORTS{~flush_i}});
`else
  assign w_cand = w_nonempty;
`endif

  // Round-robin: first candidate at or after r_rr_ptr.
  always_comb begin
    logic [PORT_W-1:0] idx;
    idx   = '0;
    w_any = 1'b0;
    w_win = '0;
    for (int unsigned i = 0; i < NR_IN_PORTS; i++) begin
      idx = PORT_W'((32'(r_rr_ptr) + i) % NR_IN_PORTS);
      if (!w_any && w_cand[idx]) begin
        w_any = 1'b1;
        w_win = idx;
      end
    end
    w_rr_next   = (w_win == PORT_W'(NR_IN_PORTS - 1)) ? '0 : w_win + PORT_W'(1);
    w_bypass    = w_any && !w_nonempty[w_win];
    w_win_entry = w_bypass ? w_in_entry[w_win] : w_head[w_win];
  end

  always_comb begin
    for (int unsigned k = 0; k < NR_IN_PORTS; k++) begin
      w_pop[k]  = w_any && !flush_i && (w_win == PORT_W'(k)) && w_nonempty[k];
      w_push[k] = in_valid_i[k] && !flush_i && (!w_fifo_full[k] || w_pop[k])
                  && !(w_bypass && (w_win == PORT_W'(k)));
      w_drop[k] = in_valid_i[k] && !flush_i && w_fifo_full[k] && !w_pop[k];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < NR_IN_PORTS; k++) begin
      if (w_push[k]) r_mem[k][r_wr_ptr[k]] <= w_in_entry[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_cnt      <= '0;
      r_rr_ptr   <= '0;
      r_overflow <= 1'b0;
    end else if (flush_i) begin
      // overflow is deliberately sticky across flush
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (w_any) r_rr_ptr <= w_rr_next;
      if (|w_drop) r_overflow <= 1'b1;
      for (int unsigned k = 0; k < NR_IN_PORTS; k++) begin
        if (w_push[k]) r_wr_ptr[k] <= r_wr_ptr[k] + PTR_W'(1);
        if (w_pop[k])  r_rd_ptr[k] <= r_rd_ptr[k] + PTR_W'(1);
        case ({w_push[k], w_pop[k]})
          2'b10:   r_cnt[k] <= r_cnt[k] + CNT_W'(1);
          2'b01:   r_cnt[k] <= r_cnt[k] - CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

  // Writeback data holds its last value when nothing wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
`ifndef WB_COLLECTOR_BYPASS_EN
      r_wb_valid <= 1'b0;
`endif
      r_wb       <= '0;
    end else if (flush_i) begin
`ifndef WB_COLLECTOR_BYPASS_EN
      r_wb_valid <= 1'b0;
`endif
    end else begin
`ifndef WB_COLLECTOR_BYPASS_EN
      r_wb_valid <= w_any;
`endif
      if (w_any) r_wb <= w_win_entry;
    end
  end

`ifdef WB_COLLECTOR_BYPASS_EN
  assign wb_valid_o = w_any && !flush_i;
  assign w_wb_out   = wb_valid_o ? w_win_entry : r_wb;
`else
  assign wb_valid_o = r_wb_valid;
  assign w_wb_out   = r_wb;
`endif

  assign wb_trans_id_o = w_wb_out.trans_id;
  assign wb_result_o   = w_wb_out.result;
  assign wb_ex_o       = w_wb_out.ex;
  assign overflow_o    = r_overflow;

endmodule

// File: doc/wb_collector.md
Name: wb_collector

Overview:
- Sits directly downstream of the execute stage, between its writeback ports and the scoreboard.
- Each execute-stage result channel (FLU, load, store, FPU, RoCC) pushes into a small per-channel FIFO.
- Round-robin arbitration drains one entry per cycle onto a single registered writeback port into the scoreboard.
- Per-channel almost-full flags give credit-style back-pressure to issue, since execute-stage outputs cannot stall.

Parameters:
NR_IN_PORTS, 5, number of writeback channels (0 FLU, 1 load, 2 store, 3 FPU, 4 RoCC).
FIFO_DEPTH, 2, entries per channel FIFO; power of two, minimum 2.
TRANS_ID_BITS, ariane_pkg::TRANS_ID_BITS, scoreboard transaction id width.

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous reset, active low
flush_i  input  1  synchronous pipeline flush
in_valid_i  input  NR_IN_PORTS  per-channel result valid
in_trans_id_i  input  NR_IN_PORTS x TRANS_ID_BITS  per-channel trans id
in_result_i  input  NR_IN_PORTS x 64  per-channel result
in_ex_i  input  NR_IN_PORTS x exception_t  per-channel exception (cause, tval, valid)
in_full_o  output  NR_IN_PORTS  almost-full; issue must not dispatch to that FU
wb_valid_o  output  1  writeback valid to scoreboard
wb_trans_id_o  output  TRANS_ID_BITS  writeback trans id
wb_result_o  output  64  writeback data
wb_ex_o  output  exception_t  writeback exception
overflow_o  output  1  sticky protocol-violation flag

Behaviour:
- Clock and reset: single clock clk_i; rst_ni asynchronous, active low.
- Reset values: all FIFOs empty, RR pointer 0, wb_valid_o 0, wb_trans_id_o 0, wb_result_o 0, wb_ex_o all zero, overflow_o 0, in_full_o 0.
- Push: in_valid_i[k] high with FIFO k not full -> entry written at the clock edge. The scoreboard always accepts; wb port has no ready.
- Arbitration: among non-empty FIFOs, pick the first at or after rr_ptr (wrapping modulo NR_IN_PORTS).
  - Winner popped; its head is registered into wb_* outputs.
  - rr_ptr <= winner+1, wrapping to 0 past NR_IN_PORTS-1.
  - No non-empty FIFO -> wb_valid_o <= 0, rr_ptr unchanged, wb data holds its previous value.
- Latency: push at edge t -> earliest wb_valid_o at edge t+1. Throughput: 1 entry per cycle total.
- Push and pop on the same FIFO in the same cycle:
  - Allowed at any occupancy, including full (count unchanged).
  - A pop on an empty FIFO cannot occur.
- in_full_o[k] = count_k >= FIFO_DEPTH-1. It is combinational from the registered count, leaving one slot for an instruction already issued.
- Overflow: push to a full FIFO with no pop that cycle -> entry dropped, overflow_o set. overflow_o stays set until reset; flush does not clear it.
- Ordering: within a channel, FIFO order is preserved. Across channels, order is not guaranteed (scoreboard tracks by trans id).
- Flush:
  - All counts and pointers zeroed; rr_ptr <= 0; wb_valid_o <= 0 next cycle.
  - Inputs presented in the flush cycle are discarded.
  - Bypass is suppressed during flush.
- Reset mid-operation: immediate return to reset values; in-flight entries lost.
- Exceptions: carried verbatim with the entry. An exception entry arbitrates like any other.

Optional Feature:
WB_COLLECTOR_BYPASS_EN
- Defined:
  - If the winning FIFO is empty and the same channel is the arbitration winner among this cycle's input valids, the input is driven combinationally onto wb_* in the same cycle, without a FIFO write.
  - wb_* become combinational outputs, and rr_ptr updates identically.
  - Arbitration then considers non-empty FIFOs plus valid inputs to empty FIFOs.
- Undefined: registered-output behaviour exactly as above (1-cycle minimum latency).

Test Plan:
- Reset then idle -> wb_valid_o=0, in_full_o=5'b00000, overflow_o=0 for 10 cycles.
- Single load push (port 1, trans_id 3, result 64'hDEAD_BEEF) -> next cycle wb_valid_o=1, wb_trans_id_o=3, wb_result_o=64'hDEAD_BEEF; the following cycle wb_valid_o=0.
- All 5 ports push once in the same cycle with rr_ptr=0 -> five consecutive writebacks in port order 0,1,2,3,4; in_full_o[k]=1 (count 1 = DEPTH-1) until port k drains.
- Port 3 pushes 3 entries back-to-back while ports 0–2 each hold 2 entries -> third port-3 push drops, overflow_o=1 and stays high through a later flush; no third port-3 writeback appears.
- Flush with 4 entries queued and new valids on ports 0 and 2 -> wb_valid_o=0 the next cycle and no writeback of any pre-flush or flush-cycle entry.
- Port 2 pushes an entry with ex.valid=1, cause=5, tval=64'h80 -> wb_ex_o carries valid=1, cause=5, tval=64'h80 with the matching trans id.
